// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures high time and period of a PWM input in duty_clk cycles, flags a stuck line
module pwm_duty_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 16'hFFFF
) (
  input  logic             duty_clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] duty_hi,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             level_stuck,
  output logic             stuck_level
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SYNC  = 3'd1;
  localparam logic [2:0] HIGH  = 3'd2;
  localparam logic [2:0] LOW   = 3'd3;
  localparam logic [2:0] STUCK = 3'd4;
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic             meta, s, prev;
  logic             rise, fall, tout;
  logic             capture, enter_stuck;
  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] hi_cnt, per_cnt, hi_nx, per_nx;
  assign rise        = s & ~prev;
  assign fall        = ~s & prev;
  assign tout        = per_cnt == TO;
  assign level_stuck = state == STUCK;
  // two-flop synchroniser followed by the edge-detect register
  always_ff @(posedge duty_clk or negedge rst_n)
    if (!rst_n) {meta, s, prev} <= 3'b000;
    else        {meta, s, prev} <= {pwm_in, meta, s};
  // next state and counter values; timeout outranks a fall so counters never pass TO
  always_comb begin
    state_nx    = state;
    hi_nx       = hi_cnt;
    per_nx      = per_cnt;
    capture     = 1'b0;
    enter_stuck = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      hi_nx    = '0;
      per_nx   = '0;
    end else begin
      case (state)
        IDLE: state_nx = SYNC;
        SYNC:
          if (rise) begin
            state_nx = HIGH;
            hi_nx    = ONE;
            per_nx   = ONE;
          end else if (tout) enter_stuck = 1'b1;
          else per_nx = per_cnt + ONE;
        HIGH:
          if (tout) enter_stuck = 1'b1;
          else if (fall) begin
            state_nx = LOW;
            per_nx   = per_cnt + ONE;
          end else begin
            hi_nx  = hi_cnt + ONE;
            per_nx = per_cnt + ONE;
          end
        LOW:
          if (rise) begin
            capture  = 1'b1;
            state_nx = HIGH;
            hi_nx    = ONE;
            per_nx   = ONE;
          end else if (tout) enter_stuck = 1'b1;
          else per_nx = per_cnt + ONE;
        STUCK:
          if (rise) begin
            state_nx = HIGH;
            hi_nx    = ONE;
            per_nx   = ONE;
          end else if (fall) begin
            state_nx = SYNC;
            per_nx   = '0;
          end
        default: state_nx = IDLE;
      endcase
      if (enter_stuck) state_nx = STUCK;
    end
  end
  // state, counters and published measurement registers
  always_ff @(posedge duty_clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      hi_cnt      <= '0;
      per_cnt     <= '0;
      duty_hi     <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      state      <= state_nx;
      hi_cnt     <= hi_nx;
      per_cnt    <= per_nx;
      meas_valid <= capture;
      if (capture) begin
        duty_hi <= hi_cnt;
        period  <= per_cnt;
      end
      if (enter_stuck) stuck_level <= s;
    end
endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: directed checks of the PWM duty meter with hand-computed expectations
module tb_pwm_duty_meter;
  logic        duty_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] d_hi, d_per, t_hi, t_per;
  logic        mv, ls, sl, t_mv, t_ls, t_sl;
  int          vectors = 0;
  int          errs = 0;
  int          cyc = 0;
  int          mv_cnt = 0;
  int          mv_last = 0;
  int          mv_gap = 0;
  int          t_mv_cnt = 0;
  int          base;

  pwm_duty_meter dut (
    .duty_clk(duty_clk), .rst_n(rst_n), .pwm_in(pwm_in), .enable(enable),
    .duty_hi(d_hi), .period(d_per), .meas_valid(mv), .level_stuck(ls), .stuck_level(sl)
  );

  pwm_duty_meter #(.CNT_W(16), .TIMEOUT(100)) dut_t (
    .duty_clk(duty_clk), .rst_n(rst_n), .pwm_in(pwm_in), .enable(enable),
    .duty_hi(t_hi), .period(t_per), .meas_valid(t_mv), .level_stuck(t_ls), .stuck_level(t_sl)
  );

  always #5 duty_clk = ~duty_clk;

  // pulse counter and spacing of meas_valid pulses, sampled on the falling edge
  always @(negedge duty_clk) begin
    cyc++;
    if (mv) begin
      mv_cnt++;
      mv_gap = cyc - mv_last;
      mv_last = cyc;
    end
    if (t_mv) t_mv_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge duty_clk);
      #1;
    end
  endtask

  task automatic pwm(input int hi, input int lo, input int n);
    repeat (n) begin
      pwm_in = 1'b1;
      tick(hi);
      pwm_in = 1'b0;
      tick(lo);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    pwm_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({d_hi, d_per, mv, ls, sl} !== 35'd0) begin
      errs++;
      $display("FAIL reset_outputs got %h exp 0", {d_hi, d_per, mv, ls, sl});
    end
    vectors++;
    if ({t_hi, t_per, t_mv, t_ls, t_sl} !== 35'd0) begin
      errs++;
      $display("FAIL reset_outputs_t got %h exp 0", {t_hi, t_per, t_mv, t_ls, t_sl});
    end
  endtask

  task automatic test_basic();
    do_reset();
    base = mv_cnt;
    enable = 1'b1;
    tick(2);
    pwm(64, 192, 4);
    pwm_in = 1'b1;
    tick(6);
    vectors++;
    if (mv_cnt - base !== 4) begin
      errs++;
      $display("FAIL basic_count got %0d exp 4", mv_cnt - base);
    end
    vectors++;
    if (mv_gap !== 256) begin
      errs++;
      $display("FAIL basic_gap got %0d exp 256", mv_gap);
    end
    vectors++;
    if (d_hi !== 16'd64 || d_per !== 16'd256) begin
      errs++;
      $display("FAIL basic_values got %0d/%0d exp 64/256", d_hi, d_per);
    end
  endtask

  task automatic test_short_periods();
    do_reset();
    base = mv_cnt;
    enable = 1'b1;
    tick(2);
    pwm(1, 2, 6);
    pwm_in = 1'b1;
    tick(1);
    pwm_in = 1'b0;
    tick(6);
    vectors++;
    if (mv_cnt - base !== 6) begin
      errs++;
      $display("FAIL short3_count got %0d exp 6", mv_cnt - base);
    end
    vectors++;
    if (mv_gap !== 3 || d_hi !== 16'd1 || d_per !== 16'd3) begin
      errs++;
      $display("FAIL short3_values got gap %0d %0d/%0d exp gap 3 1/3", mv_gap, d_hi, d_per);
    end
    base = mv_cnt;
    pwm(1, 1, 6);
    pwm_in = 1'b1;
    tick(6);
    vectors++;
    if (mv_cnt - base !== 7) begin
      errs++;
      $display("FAIL short2_count got %0d exp 7", mv_cnt - base);
    end
    vectors++;
    if (mv_gap !== 2 || d_hi !== 16'd1 || d_per !== 16'd2) begin
      errs++;
      $display("FAIL short2_values got gap %0d %0d/%0d exp gap 2 1/2", mv_gap, d_hi, d_per);
    end
  endtask

  task automatic test_stuck_high();
    do_reset();
    base = t_mv_cnt;
    enable = 1'b1;
    tick(2);
    pwm_in = 1'b1;
    tick(102);
    vectors++;
    if (t_ls !== 1'b0) begin
      errs++;
      $display("FAIL stuck_hi_early got %b exp 0", t_ls);
    end
    tick(1);
    vectors++;
    if (t_ls !== 1'b1 || t_sl !== 1'b1) begin
      errs++;
      $display("FAIL stuck_hi_flag got %b/%b exp 1/1", t_ls, t_sl);
    end
    vectors++;
    if (t_mv_cnt !== base) begin
      errs++;
      $display("FAIL stuck_hi_novalid got %0d exp %0d", t_mv_cnt, base);
    end
    pwm_in = 1'b0;
    tick(5);
    pwm(10, 20, 3);
    pwm_in = 1'b1;
    tick(6);
    vectors++;
    if (t_ls !== 1'b0) begin
      errs++;
      $display("FAIL stuck_hi_clear got %b exp 0", t_ls);
    end
    vectors++;
    if (t_mv_cnt - base !== 3 || t_hi !== 16'd10 || t_per !== 16'd30) begin
      errs++;
      $display("FAIL stuck_hi_resume got %0d %0d/%0d exp 3 10/30", t_mv_cnt - base, t_hi, t_per);
    end
  endtask

  task automatic test_stuck_low();
    do_reset();
    enable = 1'b1;
    tick(101);
    vectors++;
    if (t_ls !== 1'b0) begin
      errs++;
      $display("FAIL stuck_lo_early got %b exp 0", t_ls);
    end
    tick(1);
    vectors++;
    if (t_ls !== 1'b1 || t_sl !== 1'b0) begin
      errs++;
      $display("FAIL stuck_lo_flag got %b/%b exp 1/0", t_ls, t_sl);
    end
    pwm_in = 1'b1;
    tick(2);
    vectors++;
    if (t_ls !== 1'b1) begin
      errs++;
      $display("FAIL stuck_lo_hold got %b exp 1", t_ls);
    end
    tick(1);
    vectors++;
    if (t_ls !== 1'b0) begin
      errs++;
      $display("FAIL stuck_lo_clear got %b exp 0", t_ls);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    base = mv_cnt;
    enable = 1'b1;
    tick(2);
    pwm(20, 40, 3);
    pwm_in = 1'b1;
    tick(10);
    enable = 1'b0;
    tick(10);
    vectors++;
    if (mv_cnt - base !== 3 || d_hi !== 16'd20 || d_per !== 16'd60) begin
      errs++;
      $display("FAIL endrop_hold got %0d %0d/%0d exp 3 20/60", mv_cnt - base, d_hi, d_per);
    end
    enable = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(40);
    pwm_in = 1'b1;
    tick(30);
    vectors++;
    if (mv_cnt - base !== 3 || d_hi !== 16'd20 || d_per !== 16'd60) begin
      errs++;
      $display("FAIL endrop_discard got %0d %0d/%0d exp 3 20/60", mv_cnt - base, d_hi, d_per);
    end
    pwm_in = 1'b0;
    tick(30);
    pwm_in = 1'b1;
    tick(6);
    vectors++;
    if (mv_cnt - base !== 4 || d_hi !== 16'd30 || d_per !== 16'd60) begin
      errs++;
      $display("FAIL endrop_resume got %0d %0d/%0d exp 4 30/60", mv_cnt - base, d_hi, d_per);
    end
  endtask

  task automatic test_enable_edge();
    do_reset();
    base = mv_cnt;
    enable = 1'b1;
    tick(2);
    pwm(10, 20, 2);
    pwm_in = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(6);
    vectors++;
    if (mv_cnt - base !== 1 || d_hi !== 16'd10 || d_per !== 16'd30) begin
      errs++;
      $display("FAIL enable_edge got %0d %0d/%0d exp 1 10/30", mv_cnt - base, d_hi, d_per);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    base = mv_cnt;
    enable = 1'b1;
    tick(2);
    pwm(20, 40, 2);
    pwm_in = 1'b1;
    tick(20);
    pwm_in = 1'b0;
    tick(10);
    vectors++;
    if (mv_cnt - base !== 2 || d_hi !== 16'd20 || d_per !== 16'd60) begin
      errs++;
      $display("FAIL midrst_pre got %0d %0d/%0d exp 2 20/60", mv_cnt - base, d_hi, d_per);
    end
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({d_hi, d_per, mv, ls, sl} !== 35'd0) begin
      errs++;
      $display("FAIL midrst_async got %h exp 0", {d_hi, d_per, mv, ls, sl});
    end
    tick(1);
    rst_n = 1'b1;
    base = mv_cnt;
    tick(5);
    pwm_in = 1'b1;
    tick(15);
    pwm_in = 1'b0;
    tick(25);
    vectors++;
    if (mv_cnt !== base || d_per !== 16'd0) begin
      errs++;
      $display("FAIL midrst_first got %0d per %0d exp 0 per 0", mv_cnt - base, d_per);
    end
    pwm_in = 1'b1;
    tick(6);
    vectors++;
    if (mv_cnt - base !== 1 || d_hi !== 16'd15 || d_per !== 16'd40) begin
      errs++;
      $display("FAIL midrst_second got %0d %0d/%0d exp 1 15/40", mv_cnt - base, d_hi, d_per);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_periods();
    test_stuck_high();
    test_stuck_low();
    test_enable_drop();
    test_enable_edge();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
